// File: rtl/timer_countdown_ctrl.sv
// Countdown-timer sequencer: BCD preset configuration, per-second countdown
// and alarm handling, plus the control decode for the downstream timer register.
module timer_countdown_ctrl #(
  parameter logic [7:0] HR_MAX = 8'h23,
  parameter logic [7:0] MS_MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_set,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       btn_desactivar,
  output logic [7:0] cnt_hr,
  output logic [7:0] cnt_min,
  output logic [7:0] cnt_sec,
  output logic [1:0] field_sel,
  output logic       reg_hold,
  output logic       reg_sel,
  output logic       estado_alarma,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    RUN    = 2'd2,
    ALARM  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_DESACT,
    BTN_START,
    BTN_SET,
    BTN_NEXT,
    BTN_UP,
    BTN_DOWN
  } btn_t;

  state_t     cur_state, nxt_state;
  btn_t       btn;
  logic [7:0] pre_hr, pre_min, pre_sec;
  logic [7:0] pre_hr_nxt, pre_min_nxt, pre_sec_nxt;
  logic [7:0] cnt_hr_nxt, cnt_min_nxt, cnt_sec_nxt;
  logic [7:0] dec_hr, dec_min, dec_sec;
  logic [1:0] field_nxt;
  logic       preset_zero;
  logic       dec_zero;

  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    if (val == max)
      return 8'h00;
    else if (val[3:0] == 4'd9)
      return {val[7:4] + 4'd1, 4'd0};
    else
      return {val[7:4], val[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] max);
    if (val == 8'h00)
      return max;
    else if (val[3:0] == 4'd0)
      return {val[7:4] - 4'd1, 4'd9};
    else
      return {val[7:4], val[3:0] - 4'd1};
  endfunction

  // Only the single highest-priority button pulse is allowed to act.
  always_comb begin
    btn = BTN_NONE;
    if (btn_desactivar)
      btn = BTN_DESACT;
    else if (btn_start)
      btn = BTN_START;
    else if (btn_set)
      btn = BTN_SET;
    else if (btn_next)
      btn = BTN_NEXT;
    else if (btn_up)
      btn = BTN_UP;
    else if (btn_down)
      btn = BTN_DOWN;
  end

  // One-second borrow chain; hours never underflow because RUN never holds zero.
  always_comb begin
    dec_sec  = bcd_dec(cnt_sec, MS_MAX);
    dec_min  = (cnt_sec == 8'h00) ? bcd_dec(cnt_min, MS_MAX) : cnt_min;
    dec_hr   = (cnt_sec == 8'h00 && cnt_min == 8'h00) ? bcd_dec(cnt_hr, HR_MAX) : cnt_hr;
    dec_zero = (dec_sec == 8'h00) && (dec_min == 8'h00) && (dec_hr == 8'h00);
  end

  assign preset_zero = (pre_hr == 8'h00) && (pre_min == 8'h00) && (pre_sec == 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cur_state <= IDLE;
    else
      cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      IDLE: begin
        if (btn == BTN_START && !preset_zero)
          nxt_state = RUN;
        else if (btn == BTN_SET)
          nxt_state = CONFIG;
      end
      CONFIG: begin
        if (btn == BTN_START && !preset_zero)
          nxt_state = RUN;
        else if (btn == BTN_SET)
          nxt_state = IDLE;
      end
      RUN: begin
        if (btn == BTN_DESACT)
          nxt_state = IDLE;
        else if (tick_1hz && dec_zero)
          nxt_state = ALARM;
      end
      ALARM: begin
        if (btn == BTN_DESACT)
          nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    reg_hold      = (cur_state == IDLE) || (cur_state == ALARM);
    reg_sel       = (cur_state == RUN) || (cur_state == ALARM);
    estado_alarma = (cur_state == RUN) || (cur_state == ALARM);
    alarm         = (cur_state == ALARM);
    state         = cur_state;
  end

  // Preset only changes in CONFIG; outside RUN/ALARM the count tracks the preset.
  always_comb begin
    pre_hr_nxt  = pre_hr;
    pre_min_nxt = pre_min;
    pre_sec_nxt = pre_sec;
    cnt_hr_nxt  = cnt_hr;
    cnt_min_nxt = cnt_min;
    cnt_sec_nxt = cnt_sec;
    field_nxt   = field_sel;
    unique case (cur_state)
      IDLE: begin
        if (btn == BTN_SET)
          field_nxt = 2'd0;
        cnt_hr_nxt  = pre_hr;
        cnt_min_nxt = pre_min;
        cnt_sec_nxt = pre_sec;
      end
      CONFIG: begin
        if (btn == BTN_NEXT) begin
          field_nxt = (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
        end else if (btn == BTN_UP || btn == BTN_DOWN) begin
          case (field_sel)
            2'd0:
              pre_sec_nxt = (btn == BTN_UP) ? bcd_inc(pre_sec, MS_MAX) : bcd_dec(pre_sec, MS_MAX);
            2'd1:
              pre_min_nxt = (btn == BTN_UP) ? bcd_inc(pre_min, MS_MAX) : bcd_dec(pre_min, MS_MAX);
            default:
              pre_hr_nxt  = (btn == BTN_UP) ? bcd_inc(pre_hr, HR_MAX) : bcd_dec(pre_hr, HR_MAX);
          endcase
        end
        cnt_hr_nxt  = pre_hr_nxt;
        cnt_min_nxt = pre_min_nxt;
        cnt_sec_nxt = pre_sec_nxt;
      end
      RUN: begin
        if (btn == BTN_DESACT) begin
          cnt_hr_nxt  = pre_hr;
          cnt_min_nxt = pre_min;
          cnt_sec_nxt = pre_sec;
        end else if (tick_1hz) begin
          cnt_hr_nxt  = dec_hr;
          cnt_min_nxt = dec_min;
          cnt_sec_nxt = dec_sec;
        end
      end
      ALARM: begin
        if (btn == BTN_DESACT) begin
          cnt_hr_nxt  = pre_hr;
          cnt_min_nxt = pre_min;
          cnt_sec_nxt = pre_sec;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_hr    <= 8'h00;
      pre_min   <= 8'h00;
      pre_sec   <= 8'h00;
      cnt_hr    <= 8'h00;
      cnt_min   <= 8'h00;
      cnt_sec   <= 8'h00;
      field_sel <= 2'd0;
    end else begin
      pre_hr    <= pre_hr_nxt;
      pre_min   <= pre_min_nxt;
      pre_sec   <= pre_sec_nxt;
      cnt_hr    <= cnt_hr_nxt;
      cnt_min   <= cnt_min_nxt;
      cnt_sec   <= cnt_sec_nxt;
      field_sel <= field_nxt;
    end
  end

endmodule
